// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_ACC = 2'd1,
    DM_ACC = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  localparam logic       PORT_IF = 1'b0;
  localparam logic       PORT_DM = 1'b1;
  localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/arb_timeout_cnt.sv
// Access watchdog: load at grant, count wait cycles, flag when TIMEOUT cycles have elapsed.
module arb_timeout_cnt #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_count,
  output logic o_expire_c
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  // Loaded with 1 so the value equals the number of the access cycle in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(1);
    end else if (i_count && !o_expire_c) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_expire_c = (r_cnt == CW'(TIMEOUT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch (IF) and data (DM) ports, one access at a time, DM first.
// Build option ARB_STARVE_GUARD_EN: caps consecutive DM grants while a fetch is waiting.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned AW            = 12,
  parameter int unsigned TIMEOUT       = 15,
  parameter int unsigned MAX_DM_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  output logic          if_err,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [3:0]    dm_be,
  input  logic [AW-1:0] dm_addr,
  input  logic [31:0]   dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [31:0]   dm_rdata,
  output logic          dm_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ack,
  output logic          stall_if,
  output logic          stall_mem
);

  arb_state_t    r_state, w_state_nx;
  logic          r_port, w_port_nx;
  logic          r_if_gnt, w_if_gnt_nx, r_if_rvalid, w_if_rvalid_nx, r_if_err, w_if_err_nx;
  logic          r_dm_gnt, w_dm_gnt_nx, r_dm_rvalid, w_dm_rvalid_nx, r_dm_err, w_dm_err_nx;
  logic [31:0]   r_if_rdata, w_if_rdata_nx, r_dm_rdata, w_dm_rdata_nx;
  logic          r_mem_req, w_mem_req_nx, r_mem_we, w_mem_we_nx;
  logic [3:0]    r_mem_be, w_mem_be_nx;
  logic [AW-1:0] r_mem_addr, w_mem_addr_nx;
  logic [31:0]   r_mem_wdata, w_mem_wdata_nx;
  logic          w_dm_grant, w_if_grant, w_if_turn;
  logic          w_tmo_load, w_tmo_count, w_expire_c;
  logic [31:0]   w_rdata;
  logic          w_err;
  logic          w_unused_addr;

  assign w_unused_addr = ^{if_addr[1:0], dm_addr[1:0]};

  arb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmo_load),
    .i_count    (w_tmo_count),
    .o_expire_c (w_expire_c)
  );

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned SW = $clog2(MAX_DM_STREAK + 1);

  logic [SW-1:0] r_streak, w_streak_nx;

  assign w_if_turn = if_req && (r_streak == SW'(MAX_DM_STREAK));

  // A DM grant taken with no fetch waiting breaks the streak.
  always_comb begin
    w_streak_nx = r_streak;
    if (w_if_grant) begin
      w_streak_nx = '0;
    end else if (w_dm_grant) begin
      w_streak_nx = if_req ? r_streak + SW'(1) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_streak <= '0;
    else      r_streak <= w_streak_nx;
  end
`else
  logic w_unused_streak;

  assign w_if_turn       = 1'b0;
  assign w_unused_streak = (MAX_DM_STREAK == 0);
`endif

  always_comb begin
    w_state_nx     = r_state;
    w_port_nx      = r_port;
    w_if_gnt_nx    = 1'b0;
    w_dm_gnt_nx    = 1'b0;
    w_if_rvalid_nx = 1'b0;
    w_dm_rvalid_nx = 1'b0;
    w_if_err_nx    = 1'b0;
    w_dm_err_nx    = 1'b0;
    w_if_rdata_nx  = r_if_rdata;
    w_dm_rdata_nx  = r_dm_rdata;
    w_mem_req_nx   = r_mem_req;
    w_mem_we_nx    = r_mem_we;
    w_mem_be_nx    = r_mem_be;
    w_mem_addr_nx  = r_mem_addr;
    w_mem_wdata_nx = r_mem_wdata;
    w_dm_grant     = 1'b0;
    w_if_grant     = 1'b0;
    w_tmo_load     = 1'b0;
    w_tmo_count    = 1'b0;
    w_rdata        = '0;
    w_err          = 1'b0;
    case (r_state)
      IDLE: begin
        if (dm_req && !w_if_turn) begin
          w_dm_grant     = 1'b1;
          w_state_nx     = DM_ACC;
          w_port_nx      = PORT_DM;
          w_dm_gnt_nx    = 1'b1;
          w_mem_req_nx   = 1'b1;
          w_mem_we_nx    = dm_we;
          w_mem_be_nx    = dm_we ? dm_be : BE_WORD;
          w_mem_addr_nx  = {dm_addr[AW-1:2], 2'b00};
          w_mem_wdata_nx = dm_wdata;
          w_tmo_load     = 1'b1;
        end else if (if_req) begin
          w_if_grant     = 1'b1;
          w_state_nx     = IF_ACC;
          w_port_nx      = PORT_IF;
          w_if_gnt_nx    = 1'b1;
          w_mem_req_nx   = 1'b1;
          w_mem_we_nx    = 1'b0;
          w_mem_be_nx    = BE_WORD;
          w_mem_addr_nx  = {if_addr[AW-1:2], 2'b00};
          w_tmo_load     = 1'b1;
        end
      end
      IF_ACC, DM_ACC: begin
        // An ack on the final allowed cycle wins over the timeout.
        if (mem_ack || w_expire_c) begin
          w_rdata      = (mem_ack && !r_mem_we) ? mem_rdata : '0;
          w_err        = !mem_ack;
          w_state_nx   = RESP;
          w_mem_req_nx = 1'b0;
          w_mem_we_nx  = 1'b0;
          if (r_port == PORT_DM) begin
            w_dm_rvalid_nx = 1'b1;
            w_dm_rdata_nx  = w_rdata;
            w_dm_err_nx    = w_err;
          end else begin
            w_if_rvalid_nx = 1'b1;
            w_if_rdata_nx  = w_rdata;
            w_if_err_nx    = w_err;
          end
        end else begin
          w_tmo_count = 1'b1;
        end
      end
      RESP:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_port      <= PORT_IF;
      r_if_gnt    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_if_err    <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_gnt    <= 1'b0;
      r_dm_rvalid <= 1'b0;
      r_dm_err    <= 1'b0;
      r_dm_rdata  <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_port      <= w_port_nx;
      r_if_gnt    <= w_if_gnt_nx;
      r_if_rvalid <= w_if_rvalid_nx;
      r_if_err    <= w_if_err_nx;
      r_if_rdata  <= w_if_rdata_nx;
      r_dm_gnt    <= w_dm_gnt_nx;
      r_dm_rvalid <= w_dm_rvalid_nx;
      r_dm_err    <= w_dm_err_nx;
      r_dm_rdata  <= w_dm_rdata_nx;
      r_mem_req   <= w_mem_req_nx;
      r_mem_we    <= w_mem_we_nx;
      r_mem_be    <= w_mem_be_nx;
      r_mem_addr  <= w_mem_addr_nx;
      r_mem_wdata <= w_mem_wdata_nx;
    end
  end

  assign if_gnt    = r_if_gnt;
  assign if_rvalid = r_if_rvalid;
  assign if_rdata  = r_if_rdata;
  assign if_err    = r_if_err;
  assign dm_gnt    = r_dm_gnt;
  assign dm_rvalid = r_dm_rvalid;
  assign dm_rdata  = r_dm_rdata;
  assign dm_err    = r_dm_err;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_be    = r_mem_be;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign stall_if  = if_req & ~r_if_rvalid;
  assign stall_mem = dm_req & ~r_dm_rvalid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random single transactions against a memory model.
module tb_mem_port_arbiter;

  localparam int unsigned AW            = 12;
  localparam int unsigned TIMEOUT       = 15;
  localparam int unsigned MAX_DM_STREAK = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_gnt, if_rvalid, if_err;
  logic [AW-1:0] if_addr;
  logic [31:0]   if_rdata;
  logic          dm_req, dm_we, dm_gnt, dm_rvalid, dm_err;
  logic [3:0]    dm_be;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_wdata, dm_rdata;
  logic          mem_req, mem_we, mem_ack;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic          stall_if, stall_mem;

  int total = 0;
  int bad   = 0;
  int ack_delay  = 0;
  int req_cycles = 0;
  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .TIMEOUT(TIMEOUT), .MAX_DM_STREAK(MAX_DM_STREAK)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  function automatic logic [31:0] merge_be(logic [31:0] old_w, logic [31:0] new_w, logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Memory: acks in the (ack_delay+1)-th cycle of a held mem_req.
  initial begin : mem_model
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 32'h5A00_0000 ^ (32'(i) * 32'h0001_0101);
      ref_mem[i] = mem[i];
    end
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      if (mem_req === 1'b1) begin
        if (req_cycles == ack_delay) begin
          mem_ack = 1'b1;
          if (mem_we) mem[mem_addr[11:2]] = merge_be(mem[mem_addr[11:2]], mem_wdata, mem_be);
          else        mem_rdata = mem[mem_addr[11:2]];
        end
        req_cycles++;
      end else begin
        req_cycles = 0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Issue one access from IDLE; report grant, edges to rvalid, data and error. Leaves the DUT in IDLE.
  task automatic run_txn(input bit is_dm, input bit we, input logic [3:0] be, input logic [AW-1:0] addr,
                         input logic [31:0] wd, input int d, output bit gnt_ok, output int edges,
                         output logic [31:0] rd, output logic err);
    ack_delay = d;
    if (is_dm) begin
      dm_we = we; dm_be = be; dm_addr = addr; dm_wdata = wd; dm_req = 1'b1;
    end else begin
      if_addr = addr; if_req = 1'b1;
    end
    gnt_ok = 1'b0; edges = 0; rd = '0; err = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 1) gnt_ok = is_dm ? (dm_gnt && !if_gnt) : (if_gnt && !dm_gnt);
      if (is_dm ? dm_rvalid : if_rvalid) begin
        edges = i;
        rd    = is_dm ? dm_rdata : if_rdata;
        err   = is_dm ? dm_err : if_err;
        break;
      end
    end
    dm_req = 1'b0; if_req = 1'b0; dm_we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    total++;
    if ({if_gnt, if_rvalid, if_err, dm_gnt, dm_rvalid, dm_err, mem_req, mem_we} !== 8'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 00000000",
                      {if_gnt, if_rvalid, if_err, dm_gnt, dm_rvalid, dm_err, mem_req, mem_we});
    end
    total++;
    if ((mem_addr | mem_be | mem_wdata | if_rdata | dm_rdata) !== 32'h0) begin
      bad++; $display("FAIL reset_data: addr=%h be=%h wdata=%h if_rdata=%h dm_rdata=%h want all 0",
                      mem_addr, mem_be, mem_wdata, if_rdata, dm_rdata);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (mem_req !== 1'b0) begin bad++; $display("FAIL idle_no_req: mem_req got %b want 0", mem_req); end
  endtask

  task automatic test_fetch();
    int n;
    ack_delay = 2; if_addr = 12'h040; if_req = 1'b1;
    @(posedge clk); #1;
    total++;
    if (if_gnt !== 1'b1 || dm_gnt !== 1'b0) begin
      bad++; $display("FAIL fetch_gnt: if_gnt=%b dm_gnt=%b want 1/0", if_gnt, dm_gnt);
    end
    total++;
    if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'hF, 12'h040}) begin
      bad++; $display("FAIL fetch_mem: req=%b we=%b be=%h addr=%h want 1 0 f 040", mem_req, mem_we, mem_be, mem_addr);
    end
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (if_gnt !== 1'b0) n = -100;
      if (if_rvalid) begin n += i; break; end
    end
    // mem_req cycles 1..3, ack in the third, rvalid in the cycle after
    total++;
    if (n !== 3) begin bad++; $display("FAIL fetch_latency: got %0d want 3", n); end
    total++;
    if (if_rdata !== ref_mem[12'h040 >> 2] || if_err !== 1'b0) begin
      bad++; $display("FAIL fetch_rdata: got %h err=%b want %h err=0", if_rdata, if_err, ref_mem[12'h040 >> 2]);
    end
    total++;
    if (stall_if !== 1'b0) begin bad++; $display("FAIL fetch_stall_rvalid: got %b want 0", stall_if); end
    if_req = 1'b0;
    @(posedge clk); #1;
    total++;
    if (if_rvalid !== 1'b0) begin bad++; $display("FAIL fetch_pulse: if_rvalid got %b want 0", if_rvalid); end
  endtask

  task automatic test_priority();
    bit stall_ok, got;
    ack_delay = 1; if_addr = 12'h080; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 12'h100;
    if_req = 1'b1; dm_req = 1'b1;
    @(posedge clk); #1;
    total++;
    if (dm_gnt !== 1'b1 || if_gnt !== 1'b0 || mem_addr !== 12'h100) begin
      bad++; $display("FAIL prio_gnt: dm_gnt=%b if_gnt=%b addr=%h want 1 0 100", dm_gnt, if_gnt, mem_addr);
    end
    stall_ok = 1'b1; got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (dm_rvalid) begin got = 1'b1; break; end
      if (stall_if !== 1'b1 || if_gnt !== 1'b0) stall_ok = 1'b0;
      @(posedge clk); #1;
    end
    total++;
    if (!got || !stall_ok) begin bad++; $display("FAIL prio_stall: rvalid_seen=%b stall_ok=%b want 1 1", got, stall_ok); end
    total++;
    if (dm_rdata !== ref_mem[12'h100 >> 2] || stall_if !== 1'b1) begin
      bad++; $display("FAIL prio_dm_data: got %h stall_if=%b want %h 1", dm_rdata, stall_if, ref_mem[12'h100 >> 2]);
    end
    dm_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if (if_gnt !== 1'b1 || mem_addr !== 12'h080) begin
      bad++; $display("FAIL prio_if_next: if_gnt=%b addr=%h want 1 080", if_gnt, mem_addr);
    end
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (if_rvalid) begin got = 1'b1; break; end
    end
    total++;
    if (!got || if_rdata !== ref_mem[12'h080 >> 2]) begin
      bad++; $display("FAIL prio_if_data: seen=%b got %h want %h", got, if_rdata, ref_mem[12'h080 >> 2]);
    end
    if_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_store_byte();
    logic [31:0] wd, rd;
    bit got, g;
    int e;
    logic er;
    wd = $urandom;
    ack_delay = 0; dm_we = 1'b1; dm_be = 4'b0100; dm_addr = 12'h203; dm_wdata = wd; dm_req = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({dm_gnt, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'b0100, 12'h200, wd}) begin
      bad++; $display("FAIL sb_mem: gnt=%b we=%b be=%b addr=%h wdata=%h want 1 1 0100 200 %h",
                      dm_gnt, mem_we, mem_be, mem_addr, mem_wdata, wd);
    end
    total++;
    if (stall_mem !== 1'b1) begin bad++; $display("FAIL sb_stall: got %b want 1", stall_mem); end
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (dm_rvalid) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    total++;
    if (!got || dm_rdata !== 32'h0 || dm_err !== 1'b0 || stall_mem !== 1'b0) begin
      bad++; $display("FAIL sb_done: seen=%b rdata=%h err=%b stall=%b want 1 0 0 0", got, dm_rdata, dm_err, stall_mem);
    end
    ref_mem[12'h200 >> 2] = merge_be(ref_mem[12'h200 >> 2], wd, 4'b0100);
    dm_req = 1'b0; dm_we = 1'b0;
    @(posedge clk); #1;
    run_txn(1'b1, 1'b0, 4'hF, 12'h200, 32'h0, 0, g, e, rd, er);
    total++;
    if (!g || e !== 2 || rd !== ref_mem[12'h200 >> 2]) begin
      bad++; $display("FAIL sb_readback: gnt=%b edges=%0d got %h want 1 2 %h", g, e, rd, ref_mem[12'h200 >> 2]);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] rd;
    bit g, got;
    int e, n;
    logic er;
    run_txn(1'b1, 1'b0, 4'hF, 12'h010, 32'h0, TIMEOUT - 1, g, e, rd, er);
    total++;
    if (!g || e !== TIMEOUT + 1 || er !== 1'b0 || rd !== ref_mem[12'h010 >> 2]) begin
      bad++; $display("FAIL tmo_last_cycle_ack: gnt=%b edges=%0d err=%b rd=%h want 1 %0d 0 %h",
                      g, e, er, rd, TIMEOUT + 1, ref_mem[12'h010 >> 2]);
    end
    ack_delay = 1000; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 12'h300; dm_req = 1'b1;
    n = 0; got = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (mem_req) n++;
      if (dm_rvalid) begin got = 1'b1; break; end
    end
    total++;
    if (!got || n !== TIMEOUT) begin bad++; $display("FAIL tmo_req_cycles: seen=%b got %0d want %0d", got, n, TIMEOUT); end
    total++;
    if (dm_err !== 1'b1 || dm_rdata !== 32'h0 || mem_req !== 1'b0) begin
      bad++; $display("FAIL tmo_resp: err=%b rdata=%h mem_req=%b want 1 0 0", dm_err, dm_rdata, mem_req);
    end
    dm_req = 1'b0;
    @(posedge clk); #1;
    total++;
    if (dm_rvalid !== 1'b0 || dm_err !== 1'b0) begin
      bad++; $display("FAIL tmo_pulse: rvalid=%b err=%b want 0 0", dm_rvalid, dm_err);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    bit g;
    int e;
    logic er;
    ack_delay = 1000; dm_we = 1'b1; dm_be = 4'hF; dm_addr = 12'h044; dm_wdata = 32'hDEAD_BEEF; dm_req = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (mem_req !== 1'b1) begin bad++; $display("FAIL rstmid_pre: mem_req got %b want 1", mem_req); end
    rst = 1'b0;
    #1;
    total++;
    if ({mem_req, mem_we, dm_gnt, dm_rvalid, if_gnt, if_rvalid} !== 6'b0) begin
      bad++; $display("FAIL rstmid_outputs: got %b want 000000", {mem_req, mem_we, dm_gnt, dm_rvalid, if_gnt, if_rvalid});
    end
    dm_req = 1'b0; dm_we = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    run_txn(1'b1, 1'b0, 4'hF, 12'h044, 32'h0, 0, g, e, rd, er);
    total++;
    if (!g || e !== 2 || er !== 1'b0 || rd !== ref_mem[12'h044 >> 2]) begin
      bad++; $display("FAIL rstmid_after: gnt=%b edges=%0d err=%b rd=%h want 1 2 0 %h", g, e, er, rd, ref_mem[12'h044 >> 2]);
    end
  endtask

  task automatic test_starve();
    int dm_grants;
    bit if_granted;
    ack_delay = 0; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 12'h000; if_addr = 12'h0C0;
    dm_req = 1'b1; if_req = 1'b1;
    dm_grants = 0; if_granted = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (if_gnt) begin if_granted = 1'b1; break; end
      if (dm_gnt) dm_grants++;
      if (dm_grants >= 8) break;
    end
    total++;
`ifdef ARB_STARVE_GUARD_EN
    if (!if_granted || dm_grants !== MAX_DM_STREAK) begin
      bad++; $display("FAIL starve_guard: if_granted=%b dm_grants=%0d want 1 %0d", if_granted, dm_grants, MAX_DM_STREAK);
    end
`else
    if (if_granted || dm_grants !== 8) begin
      bad++; $display("FAIL strict_priority: if_granted=%b dm_grants=%0d want 0 8", if_granted, dm_grants);
    end
`endif
    dm_req = 1'b0; if_req = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    bit is_dm, we, g, exp_to;
    logic [3:0] be;
    logic [AW-1:0] addr;
    logic [31:0] wd, rd, exp_rd;
    logic er;
    int d, r, e, exp_e;
    for (int t = 0; t < 30; t++) begin
      is_dm = 1'($urandom_range(0, 1));
      we    = is_dm ? 1'($urandom_range(0, 1)) : 1'b0;
      be    = 4'($urandom_range(1, 15));
      addr  = AW'($urandom_range(0, 255));
      wd    = $urandom;
      r     = int'($urandom_range(0, 10));
      d     = (r < 7) ? (r % 4) : (13 + r - 7);
      exp_to = (d >= TIMEOUT);
      exp_e  = exp_to ? TIMEOUT + 1 : d + 2;
      exp_rd = (exp_to || we) ? 32'h0 : ref_mem[addr[11:2]];
      run_txn(is_dm, we, be, addr, wd, d, g, e, rd, er);
      if (!exp_to && we) ref_mem[addr[11:2]] = merge_be(ref_mem[addr[11:2]], wd, be);
      total++;
      if (!g) begin bad++; $display("FAIL rand_gnt[%0d]: port_dm=%b grant not seen", t, is_dm); end
      total++;
      if (e !== exp_e) begin bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d (d=%0d)", t, e, exp_e, d); end
      total++;
      if (rd !== exp_rd) begin bad++; $display("FAIL rand_rdata[%0d]: got %h want %h", t, rd, exp_rd); end
      total++;
      if (er !== exp_to) begin bad++; $display("FAIL rand_err[%0d]: got %b want %b", t, er, exp_to); end
    end
  endtask

  initial begin : main
    rst = 1'b0; if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
    test_reset();
    test_fetch();
    test_priority();
    test_store_byte();
    test_timeout();
    test_reset_mid();
    test_starve();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
